pattern_bist_ctrl: RTL and testbench
====================================

PATTERN_BIST_CTRL -- requirements
Module: pattern_bist_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of vector-count input and internal counter.
REQ-002 Parameter LAT, default 2, range 1..8: cycles from stim_valid of a vector to its rsp sample at the netlist under test.
REQ-003 blif_clk_net  in  1  single clock; all state updates on its rising edge.
REQ-004 blif_reset_net  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a run.
REQ-006 seed  in  11  LFSR seed, sampled on an accepted start.
REQ-007 num_vec  in  CNT_W  number of vectors to apply, sampled on an accepted start.
REQ-008 stim  out  11  stimulus vector driven to the netlist primary inputs.
REQ-009 stim_valid  out  1  stim holds a vector counted in this run.
REQ-010 rsp  in  11  netlist primary outputs.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 sig  out  11  final MISR signature.
REQ-013 sig_valid  out  1  sig is valid; held until accepted.
REQ-014 sig_ready  in  1  consumer accepts sig when sig_valid and sig_ready are both high.

Function
REQ-015 States: IDLE, RUN, DRAIN, SIG; only IDLE accepts start.
REQ-016 IDLE + start: load LFSR with seed (11'h001 if seed==0), clear MISR, load counter with num_vec; go to RUN, or to SIG when num_vec==0.
REQ-017 RUN: each cycle stim=LFSR, stim_valid=1, LFSR <= {q[9:0], q[10]^q[8]}, counter decrements; after the num_vec-th vector go to DRAIN.
REQ-018 stim_valid is delayed by an LAT-stage shift register; when its last stage is 1, MISR <= {m[9:0], m[10]^m[8]} ^ rsp.
REQ-019 DRAIN: stim_valid=0, stim holds its last value; leave for SIG when the delay register is all zero, so exactly num_vec responses are compacted.
REQ-020 SIG: sig=MISR, sig_valid=1; on handshake go to IDLE and drop sig_valid the next cycle; sig is stable while sig_valid is high.
REQ-021 First stim_valid occurs the cycle after start; the run lasts num_vec+LAT cycles in RUN+DRAIN before sig_valid.
REQ-022 start outside IDLE is ignored; sig_valid is never asserted without a completed run.
REQ-023 Counter is CNT_W wide; num_vec = 2^CNT_W-1 runs to completion without wrap.

Reset
REQ-024 blif_reset_net high at an edge forces IDLE, LFSR=11'h001, MISR=0, counter=0, delay register=0; stim=0, stim_valid=0, busy=0, sig=0, sig_valid=0.
REQ-025 Reset mid-run aborts without producing a signature; start in the cycle reset is high is ignored.

Configuration
REQ-026 Macro BIST_RSP_MASK_EN defined: extra input rsp_mask[10:0]; bits set in rsp_mask are forced to 0 before MISR compaction.
REQ-027 BIST_RSP_MASK_EN undefined: no rsp_mask port; all rsp bits are compacted.

Verification
REQ-028 seed=0, num_vec=10, LAT=2: stim = 001,002,004,008,010,020,040,080,100,201 (hex) on consecutive cycles.
REQ-029 rsp=11'h001 constant, num_vec=1 -> sig=11'h001; num_vec=2 -> sig=11'h003.
REQ-030 num_vec=0 -> no stim_valid; sig_valid the cycle after start with sig=0.
REQ-031 sig_ready held low 5 cycles in SIG -> sig_valid and sig stable; start pulses ignored; IDLE one cycle after the handshake.
REQ-032 Reset asserted on the 4th RUN cycle -> all outputs 0 the next cycle; sig_valid never rises; a new start then runs normally.
REQ-033 BIST_RSP_MASK_EN defined, rsp_mask=11'h7FF, rsp random, num_vec=20 -> sig=0.

Source files
------------

// File: rtl/pattern_bist_ctrl.sv
// Pattern BIST controller: drives 11-bit LFSR stimulus into a netlist under
// test, compacts its delayed responses in an 11-bit MISR and hands the final
// signature to a consumer through a valid/ready handshake.
// Optional feature: define BIST_RSP_MASK_EN to add the rsp_mask input, whose
// set bits are forced to 0 before compaction.
module pattern_bist_ctrl #(
   parameter int CNT_W = 16,
   parameter int LAT   = 2
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             start,
   input  logic [10:0]      seed,
   input  logic [CNT_W-1:0] num_vec,
   output logic [10:0]      stim,
   output logic             stim_valid,
   input  logic [10:0]      rsp,
`ifdef BIST_RSP_MASK_EN
   input  logic [10:0]      rsp_mask,
`endif
   output logic             busy,
   output logic [10:0]      sig,
   output logic             sig_valid,
   input  logic             sig_ready
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_SIG} state_t;

   state_t           state_q, state_d;
   logic [10:0]      lfsr_q, lfsr_d;
   logic [10:0]      misr_q, misr_d;
   logic [10:0]      hold_q, hold_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LAT-1:0]   dly_q, dly_d;
   logic [10:0]      rsp_eff;

   function automatic logic [10:0] lfsr_step(input logic [10:0] q);
      return {q[9:0], q[10] ^ q[8]};
   endfunction

   function automatic logic [10:0] misr_step(input logic [10:0] m, input logic [10:0] r);
      return {m[9:0], m[10] ^ m[8]} ^ r;
   endfunction

`ifdef BIST_RSP_MASK_EN
   assign rsp_eff = rsp & ~rsp_mask;
`else
   assign rsp_eff = rsp;
`endif

   // stim follows the LFSR while vectors are being applied and otherwise
   // shows the last applied vector, so DRAIN keeps the inputs steady.
   assign stim_valid = (state_q == S_RUN);
   assign stim       = stim_valid ? lfsr_q : hold_q;
   assign busy       = (state_q != S_IDLE);
   assign sig_valid  = (state_q == S_SIG);
   assign sig        = sig_valid ? misr_q : 11'd0;

   // The valid delay line marks the cycle in which each vector's response
   // is present on rsp; its last stage enables compaction.
   if (LAT == 1) begin : g_dly1
      assign dly_d = stim_valid;
   end else begin : g_dlyn
      assign dly_d = {dly_q[LAT-2:0], stim_valid};
   end

   // Next-state, LFSR, MISR and vector counter updates.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      if (dly_q[LAT-1]) begin
         misr_d = misr_step(misr_q, rsp_eff);
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               lfsr_d  = (seed == 11'd0) ? 11'h001 : seed;
               misr_d  = 11'd0;
               cnt_d   = num_vec;
               state_d = (num_vec == '0) ? S_SIG : S_RUN;
            end
         end
         S_RUN: begin
            lfsr_d = lfsr_step(lfsr_q);
            hold_d = lfsr_q;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Leave as the final response is compacted at this edge, so the
            // signature is complete on the first SIG cycle.
            if (dly_d == '0) begin
               state_d = S_SIG;
            end
         end
         S_SIG: begin
            if (sig_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset aborts any run and clears all datapath state.
   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         state_q <= S_IDLE;
         lfsr_q  <= 11'h001;
         misr_q  <= 11'd0;
         hold_q  <= 11'd0;
         cnt_q   <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
      end
   end

endmodule

// File: tb/tb_pattern_bist_ctrl.sv
// Self-checking bench for pattern_bist_ctrl: a run-level reference model
// (phase, cycle index within the run, expected vector and signature) is
// compared with the DUT every cycle, plus literal expectations for the
// documented example runs.
module tb_pattern_bist_ctrl;
   localparam int CNT_W = 8;
   localparam int LAT   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             sig_ready = 1'b0;
   logic [10:0]      seed = 11'd0;
   logic [10:0]      rsp = 11'd0;
   logic [10:0]      msk = 11'd0;
   logic [CNT_W-1:0] num_vec = '0;
   logic [10:0]      stim, sig;
   logic             stim_valid, busy, sig_valid;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   bit rsp_rand = 1'b0;

   pattern_bist_ctrl #(.CNT_W(CNT_W), .LAT(LAT)) dut (
      .blif_clk_net   (clk),
      .blif_reset_net (rst),
      .start          (start),
      .seed           (seed),
      .num_vec        (num_vec),
      .stim           (stim),
      .stim_valid     (stim_valid),
      .rsp            (rsp),
`ifdef BIST_RSP_MASK_EN
      .rsp_mask       (msk),
`endif
      .busy           (busy),
      .sig            (sig),
      .sig_valid      (sig_valid),
      .sig_ready      (sig_ready)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input int a, input int e);
      total++;
      if (a != e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
      end
   endtask

   // Feedback shift used for both the stimulus sequence and the signature.
   function automatic logic [10:0] nxt(input logic [10:0] v);
      return ((v << 1) & 11'h7FF) | 11'(((v >> 10) ^ (v >> 8)) & 11'd1);
   endfunction

   // Reference model. ph: 0 idle, 1 applying/draining, 2 signature offered.
   // k is the 1-based cycle index since the accepted start; vector j is
   // driven in cycle j and its response is compacted in cycle j+LAT.
   int          ph = 0;
   int          k = 0;
   int          mN = 0;
   logic [10:0] vec = 11'd0;
   logic [10:0] msig = 11'd0;

   always @(posedge clk) begin
      if (rst) begin
         ph = 0;
      end else begin
         case (ph)
            0: if (start) begin
               mN   = int'(num_vec);
               vec  = (seed == 11'd0) ? 11'h001 : seed;
               msig = 11'd0;
               k    = 1;
               ph   = (mN == 0) ? 2 : 1;
            end
            1: begin
               if (k > LAT) msig = nxt(msig) ^ (rsp & ~msk);
               if (k < mN) vec = nxt(vec);
               if (k == mN + LAT) ph = 2;
               else k++;
            end
            default: if (sig_ready) ph = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (ph == 0) begin
            cmp("idle_busy", busy, 0);
            cmp("idle_stim_valid", stim_valid, 0);
            cmp("idle_sig_valid", sig_valid, 0);
         end else if (ph == 1) begin
            cmp("run_busy", busy, 1);
            cmp("run_stim_valid", stim_valid, int'(k <= mN));
            cmp("run_stim", stim, vec);
            cmp("run_sig_valid", sig_valid, 0);
         end else begin
            cmp("sig_busy", busy, 1);
            cmp("sig_stim_valid", stim_valid, 0);
            cmp("sig_sig_valid", sig_valid, 1);
            cmp("sig_value", sig, msig);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rsp_rand) rsp = 11'($urandom);
   endtask

   task automatic wait_sig(input int budget, output int n);
      n = 0;
      while (!sig_valid && n < budget) begin
         tick();
         n++;
      end
      cmp("sig_wait", sig_valid, 1);
   endtask

   task automatic handshake();
      sig_ready = 1'b1;
      tick();
      sig_ready = 1'b0;
      cmp("idle_after_hs", busy, 0);
      cmp("sigv_after_hs", sig_valid, 0);
   endtask

   task automatic launch(input logic [10:0] s, input int n);
      seed    = s;
      num_vec = CNT_W'(n);
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   logic [10:0] exp28 [10];
   logic [10:0] s0;
   int          n;

   initial begin
      exp28 = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010,
                11'h020, 11'h040, 11'h080, 11'h100, 11'h201};

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      cmp("rst_busy", busy, 0);
      cmp("rst_stim", stim, 0);
      cmp("rst_stim_valid", stim_valid, 0);
      cmp("rst_sig", sig, 0);
      cmp("rst_sig_valid", sig_valid, 0);
      rst = 1'b0;
      chk_en = 1'b1;
      tick();

      // Zero seed maps to 001; documented ten-vector sequence
      launch(11'd0, 10);
      for (int i = 0; i < 10; i++) begin
         cmp($sformatf("seq_%0d", i), stim, exp28[i]);
         tick();
      end
      wait_sig(100, n);
      cmp("len_seq", n, LAT);
      handshake();

      // Constant response 001
      rsp = 11'h001;
      launch(11'h5A5, 1);
      wait_sig(50, n);
      cmp("len_n1", n, 3);
      cmp("sig_n1", sig, 11'h001);
      handshake();
      launch(11'h123, 2);
      wait_sig(50, n);
      cmp("len_n2", n, 4);
      cmp("sig_n2", sig, 11'h003);
      handshake();

      // Empty run
      launch(11'h3C3, 0);
      cmp("n0_sig_valid", sig_valid, 1);
      cmp("n0_sig", sig, 0);
      cmp("n0_stim_valid", stim_valid, 0);
      handshake();

      // Consumer stalls with start pulses in SIG
      rsp_rand = 1'b1;
      launch(11'h0F0, 3);
      wait_sig(50, n);
      s0 = sig;
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 1);
         tick();
         cmp("stall_sig_valid", sig_valid, 1);
         cmp("stall_sig_hold", sig, s0);
      end
      start = 1'b0;
      handshake();

      // Reset on the 4th RUN cycle, with a start in the same cycle
      launch(11'h2AB, 20);
      tick();
      tick();
      tick();
      rst   = 1'b1;
      start = 1'b1;
      tick();
      cmp("abort_busy", busy, 0);
      cmp("abort_stim", stim, 0);
      cmp("abort_stim_valid", stim_valid, 0);
      cmp("abort_sig", sig, 0);
      cmp("abort_sig_valid", sig_valid, 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      cmp("abort_start_ignored", busy, 0);
      for (int i = 0; i < 30; i++) tick();
      launch(11'h011, 5);
      wait_sig(50, n);
      cmp("len_after_abort", n, 5 + LAT);
      handshake();

`ifdef BIST_RSP_MASK_EN
      // Fully masked responses leave the signature at zero
      msk = 11'h7FF;
      launch(11'h4D2, 20);
      wait_sig(100, n);
      cmp("mask_all_sig", sig, 0);
      handshake();
      msk = 11'd0;
`endif

      // Randomized runs with random ready and stray start pulses
      for (int r = 0; r < 10; r++) begin
`ifdef BIST_RSP_MASK_EN
         msk = 11'($urandom);
`endif
         launch(11'($urandom), $urandom_range(1, 40));
         n = 0;
         while (busy && n < 500) begin
            sig_ready = 1'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            tick();
            n++;
         end
         start = 1'b0;
         sig_ready = 1'b0;
         cmp("rand_done", busy, 0);
      end
      msk = 11'd0;

      // Largest vector count for the counter width
      launch(11'($urandom), (1 << CNT_W) - 1);
      wait_sig(600, n);
      cmp("len_full", n, (1 << CNT_W) - 1 + LAT);
      handshake();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
